// File: rtl/pcs_rx_descramble_lock_if.sv
// 64b/66b RX block bus: gearbox-side blocks in, descrambled locked blocks out.
// The master drives rx_*, the slave (lock/descrambler) drives out_* and status.
interface pcs_rx_descramble_lock_if #(
  parameter int DW = 64,
  parameter int HW = 2
);
  logic [DW-1:0] rx_data;
  logic [HW-1:0] rx_hdr;
  logic          rx_valid;
  logic [DW-1:0] out_data;
  logic [HW-1:0] out_hdr;
  logic          out_valid;
  logic          out_hdr_err;
  logic          block_lock;
  logic          bitslip;

  modport master (
    output rx_data,
    output rx_hdr,
    output rx_valid,
    input  out_data,
    input  out_hdr,
    input  out_valid,
    input  out_hdr_err,
    input  block_lock,
    input  bitslip
  );

  modport slave (
    input  rx_data,
    input  rx_hdr,
    input  rx_valid,
    output out_data,
    output out_hdr,
    output out_valid,
    output out_hdr_err,
    output block_lock,
    output bitslip
  );
endinterface

// File: rtl/pcs_rx_descramble_lock.sv
// RX 64b/66b block path: sync-header check, block-lock FSM with bitslip,
// and x^58+x^39+1 self-synchronizing descrambler.
module pcs_rx_descramble_lock #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          HDR_WIDTH     = 2,
  parameter logic [57:0] LFSR_INIT     = {58{1'b1}},
  parameter int          LOCK_COUNT    = 64,
  parameter int          UNLOCK_WINDOW = 64,
  parameter int          UNLOCK_BAD    = 16,
  parameter int          SLIP_HOLDOFF  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  pcs_rx_descramble_lock_if.slave     bus
);

  localparam int SHW = $clog2(LOCK_COUNT + 1);
  localparam int WNW = $clog2(UNLOCK_WINDOW + 1);
  localparam int BDW = $clog2(UNLOCK_BAD + 1);
  localparam int SLW = $clog2(SLIP_HOLDOFF + 1);
  localparam int HIW = 58;

  localparam logic [SHW-1:0] SH_TERM   = SHW'(LOCK_COUNT);
  localparam logic [WNW-1:0] WIN_TERM  = WNW'(UNLOCK_WINDOW);
  localparam logic [BDW-1:0] BAD_TERM  = BDW'(UNLOCK_BAD);
  localparam logic [SLW-1:0] SLIP_TERM = SLW'(SLIP_HOLDOFF);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    LOCKED
  } state_e;

  state_e                  state_q;
  logic [SHW-1:0]          sh_cnt_q;
  logic [WNW-1:0]          win_cnt_q;
  logic [BDW-1:0]          bad_cnt_q;
  logic [SLW-1:0]          slip_cnt_q;
  logic [HIW-1:0]          hist_q;
  logic [HIW-1:0]          hist_d;

  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [HDR_WIDTH-1:0]    out_hdr_q;
  logic                    out_valid_q;
  logic                    out_hdr_err_q;
  logic                    block_lock_q;
  logic                    bitslip_q;

  logic                    hdr_ok;
  logic [SHW-1:0]          sh_nxt;
  logic [WNW-1:0]          win_nxt;
  logic [BDW-1:0]          bad_nxt;
  logic [SLW-1:0]          slip_nxt;
  logic [DATA_WIDTH+HIW-1:0] ext;
  logic [DATA_WIDTH-1:0]   descr;

  // ext[j] is the scrambled stream with history at the bottom:
  // input bit i sits at ext[i+58], so S(i-39)=ext[i+19], S(i-58)=ext[i].
  always_comb begin
    ext    = {bus.rx_data, hist_q};
    descr  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      descr[i] = bus.rx_data[i] ^ ext[i+19] ^ ext[i];
    end
    hist_d = bus.rx_data[DATA_WIDTH-1:DATA_WIDTH-HIW];
  end

  always_comb begin
    hdr_ok   = ^bus.rx_hdr;
    sh_nxt   = sh_cnt_q + SHW'(1);
    win_nxt  = win_cnt_q + WNW'(1);
    bad_nxt  = bad_cnt_q + BDW'(!hdr_ok);
    slip_nxt = slip_cnt_q + SLW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      sh_cnt_q      <= '0;
      win_cnt_q     <= '0;
      bad_cnt_q     <= '0;
      slip_cnt_q    <= '0;
      hist_q        <= LFSR_INIT;
      out_data_q    <= '0;
      out_hdr_q     <= '0;
      out_valid_q   <= 1'b0;
      out_hdr_err_q <= 1'b0;
      block_lock_q  <= 1'b0;
      bitslip_q     <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      out_hdr_err_q <= 1'b0;
      bitslip_q     <= 1'b0;
      if (bus.rx_valid) begin
        hist_q        <= hist_d;
        out_data_q    <= descr;
        out_hdr_q     <= bus.rx_hdr;
        out_valid_q   <= (state_q == LOCKED);
        out_hdr_err_q <= (state_q == LOCKED) && !hdr_ok;
        unique case (state_q)
          HUNT: begin
            if (hdr_ok) begin
              if (sh_nxt == SH_TERM) begin
                state_q      <= LOCKED;
                block_lock_q <= 1'b1;
                sh_cnt_q     <= '0;
                win_cnt_q    <= '0;
                bad_cnt_q    <= '0;
              end else begin
                sh_cnt_q <= sh_nxt;
              end
            end else begin
              state_q    <= SLIP;
              bitslip_q  <= 1'b1;
              sh_cnt_q   <= '0;
              slip_cnt_q <= '0;
            end
          end
          SLIP: begin
            if (slip_nxt == SLIP_TERM) begin
              state_q    <= HUNT;
              sh_cnt_q   <= '0;
              slip_cnt_q <= '0;
            end else begin
              slip_cnt_q <= slip_nxt;
            end
          end
          LOCKED: begin
            // Losing lock takes priority over a window rollover.
            if (bad_nxt == BAD_TERM) begin
              state_q      <= SLIP;
              block_lock_q <= 1'b0;
              bitslip_q    <= 1'b1;
              slip_cnt_q   <= '0;
              win_cnt_q    <= '0;
              bad_cnt_q    <= '0;
            end else if (win_nxt == WIN_TERM) begin
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_nxt;
              bad_cnt_q <= bad_nxt;
            end
          end
          default: begin
            state_q      <= HUNT;
            block_lock_q <= 1'b0;
            sh_cnt_q     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_hdr     = out_hdr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_hdr_err = out_hdr_err_q;
  assign bus.block_lock  = block_lock_q;
  assign bus.bitslip     = bitslip_q;

endmodule

// File: tb/tb_pcs_rx_descramble_lock.sv
// Scoreboard bench for pcs_rx_descramble_lock: serial TX scrambler feeds
// the DUT, a behavioural lock model predicts lock/slip/valid per cycle.
module tb_pcs_rx_descramble_lock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcs_rx_descramble_lock_if bus ();

  pcs_rx_descramble_lock dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ov;
    logic [63:0] d;
    logic [1:0]  h;
    logic        he;
    logic        lock;
    logic        slip;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [57:0] tx_st;
  int   m_state, m_sh, m_slip, m_win, m_bad;
  int   lock_at;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble(input logic [63:0] pt, output logic [63:0] sd);
    logic b;
    sd = '0;
    for (int i = 0; i < 64; i++) begin
      b     = pt[i] ^ tx_st[38] ^ tx_st[57];
      sd[i] = b;
      tx_st = {tx_st[56:0], b};
    end
  endtask

  task automatic model(input logic v, input logic [1:0] h,
                       input logic [63:0] pt, output exp_t e);
    logic ok;
    ok     = h[0] ^ h[1];
    e.ov   = 1'b0;
    e.d    = pt;
    e.h    = h;
    e.he   = 1'b0;
    e.slip = 1'b0;
    if (v) begin
      e.ov = (m_state == 2);
      e.he = e.ov && !ok;
      case (m_state)
        0: begin
          if (ok) begin
            m_sh++;
            if (m_sh == 64) begin
              m_state = 2; m_sh = 0; m_win = 0; m_bad = 0;
            end
          end else begin
            e.slip = 1'b1; m_sh = 0; m_slip = 0; m_state = 1;
          end
        end
        1: begin
          m_slip++;
          if (m_slip == 4) begin
            m_state = 0; m_sh = 0;
          end
        end
        default: begin
          m_win++;
          if (!ok) m_bad++;
          if (m_bad == 16) begin
            e.slip = 1'b1; m_state = 1; m_slip = 0; m_win = 0; m_bad = 0;
          end else if (m_win == 64) begin
            m_win = 0; m_bad = 0;
          end
        end
      endcase
    end
    e.lock = (m_state == 2);
  endtask

  task automatic send(input logic v, input logic [1:0] h,
                      input logic [63:0] pt);
    exp_t        e;
    logic [63:0] sd;
    @(negedge clk);
    rst = 1'b0;
    if (v) scramble(pt, sd);
    else   sd = {$urandom, $urandom};
    bus.rx_valid = v;
    bus.rx_hdr   = h;
    bus.rx_data  = sd;
    model(v, h, pt, e);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      e = '{ov: 1'b0, d: 64'h0, h: 2'b00, he: 1'b0, lock: 1'b0, slip: 1'b0};
      sb.push_back(e);
    end
    m_state = 0; m_sh = 0; m_slip = 0; m_win = 0; m_bad = 0;
    tx_st   = '1;
  endtask

  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("lock", 64'(bus.block_lock), 64'(e.lock));
      chk("slip", 64'(bus.bitslip), 64'(e.slip));
      chk("ov", 64'(bus.out_valid), 64'(e.ov));
      if (e.ov) begin
        chk("data", bus.out_data, e.d);
        chk("hdr", 64'(bus.out_hdr), 64'(e.h));
        chk("herr", 64'(bus.out_hdr_err), 64'(e.he));
      end
    end
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_hdr   = 2'b00;
    bus.rx_data  = 64'h0;
    tx_st   = '1;
    m_state = 0; m_sh = 0; m_slip = 0; m_win = 0; m_bad = 0;

    do_reset(3);
    @(posedge clk); #2;
    chk("rst_lock", 64'(bus.block_lock), 64'd0);
    chk("rst_slip", 64'(bus.bitslip), 64'd0);
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_data", bus.out_data, 64'h0);

    for (int i = 1; i <= 64; i++) send(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #2;
    chk("acq_lock", 64'(bus.block_lock), 64'd1);
    send(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #2;
    chk("acq_ov", 64'(bus.out_valid), 64'd1);
    chk("acq_data", bus.out_data, 64'h0123_4567_89AB_CDEF);

    do_reset(1);
    lock_at = 0;
    for (int i = 1; i <= 100 && lock_at == 0; i++) begin
      send(1'b1, (i == 10) ? 2'b00 : 2'b01, {$urandom, $urandom});
      @(posedge clk); #2;
      if (i == 10) chk("hunt_slip", 64'(bus.bitslip), 64'd1);
      if (bus.block_lock) lock_at = i;
    end
    chk("hunt_lock_at", 64'(lock_at), 64'd78);

    for (int i = 1; i <= 64; i++)
      send(1'b1, (i >= 20 && i < 35) ? 2'b11 : 2'b10, {$urandom, $urandom});
    @(posedge clk); #2;
    chk("win15_lock", 64'(bus.block_lock), 64'd1);
    for (int i = 1; i <= 16; i++) send(1'b1, 2'b00, {$urandom, $urandom});
    @(posedge clk); #2;
    chk("unl_lock", 64'(bus.block_lock), 64'd0);
    chk("unl_slip", 64'(bus.bitslip), 64'd1);
    chk("unl_herr", 64'(bus.out_hdr_err), 64'd1);
    chk("unl_ov", 64'(bus.out_valid), 64'd1);

    for (int i = 1; i <= 68; i++) send(1'b1, 2'b01, {$urandom, $urandom});
    @(posedge clk); #2;
    chk("relock", 64'(bus.block_lock), 64'd1);

    for (int i = 1; i <= 200; i++) begin
      repeat ($urandom_range(0, 3)) send(1'b0, 2'($urandom), 64'h0);
      send(1'b1, ($urandom % 2) ? 2'b01 : 2'b10, {$urandom, $urandom});
    end

    do_reset(1);
    @(posedge clk); #2;
    chk("mid_rst_lock", 64'(bus.block_lock), 64'd0);
    chk("mid_rst_slip", 64'(bus.bitslip), 64'd0);
    for (int i = 1; i <= 64; i++) send(1'b1, 2'b10, {$urandom, $urandom});
    @(posedge clk); #2;
    chk("mid_relock", 64'(bus.block_lock), 64'd1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
